bs_arbtr_wrr: RTL and testbench
===============================

Name: bs_arbtr_wrr

Overview:
- Parametrised successor of the bus generator/arbiter: BITS independent buses, each shared by DRVRS devices.
- Per bus, a weighted round-robin arbiter pops one packet from a pending device, decodes the destination field, then pushes the packet to one device or broadcasts it.
- New relative to the previous generation: per-device weights, destination backpressure (full), a wait timeout, and drop accounting for illegal addresses.
- Sits between device FIFOs (pndng/pop/D_pop) and device input queues (push/D_push/full).

Parameters:
BITS, 1, number of independent buses
DRVRS, 4, devices per bus (2..16)
PCKG_SZ, 16, packet width in bits
ADDR_W, 8, destination field width; field is D_pop[PCKG_SZ-1 -: ADDR_W]
BROADCAST, {ADDR_W{1'b1}}, destination value meaning all devices except source
WEIGHT_W, 4, width of per-device weight
TMO, 64, cycles a packet may wait on full before being dropped
CNT_W, 16, drop counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
pndng  in  BITS*DRVRS  device has a packet at FIFO head
D_pop  in  BITS*DRVRS*PCKG_SZ  FIFO head data, valid while pndng
pop  out  BITS*DRVRS  one-cycle dequeue strobe
full  in  BITS*DRVRS  destination queue cannot accept
push  out  BITS*DRVRS  one-cycle enqueue strobe
D_push  out  BITS*DRVRS*PCKG_SZ  packet data (same value to all lanes of a bus)
cfg_weight  in  DRVRS*WEIGHT_W  grant credits per device, shared by all buses; 0 treated as 1
busy  out  BITS  bus not in IDLE
drop_cnt  out  BITS*CNT_W  dropped packets per bus, saturating

Behaviour:
- Reset (async, reset=0): pop=0, push=0, D_push=0, busy=0, drop_cnt=0. Every bus goes to IDLE, priority pointer=0, credit=weight of device 0. An in-flight packet is discarded without push.
- Per-bus FSM, fully independent per bus.
- IDLE: if any pndng, grant per WRR and go to POP; else stay.
- POP: pop[g]=1 for exactly 1 cycle; latch D_pop[g] and source id g at that edge. Go to ROUTE.
- ROUTE: decode addr. If addr==BROADCAST, mask = all devices except g. If addr<DRVRS, mask = one-hot(addr); self-address is allowed. Otherwise increment drop_cnt and go to IDLE. With a legal mask: if (full & mask)==0 go to PUSH, else go to WAIT with the timeout counter cleared.
- WAIT: each cycle, if (full & mask)==0 go to PUSH. Else, when the timeout counter reaches TMO-1, increment drop_cnt and go to IDLE. Otherwise increment the timeout counter.
- PUSH: push=mask for 1 cycle; D_push = latched packet on all lanes, held until the next PUSH. Go to IDLE.
- Latency: pndng seen in IDLE at cycle 0 -> pop at cycle 1 -> push at cycle 3 (no backpressure). Minimum 4 cycles per packet per bus.
- Broadcast is all-or-nothing: no push until every masked device is not full.
- WRR grant:
  - If the device at the pointer is pending and credit>0, grant it and decrement credit.
  - Otherwise advance the pointer cyclically to the next pending device, reload credit = weight-1, grant it.
  - A credited device that is no longer pending forfeits its remaining credits.
- cfg_weight is sampled only at reload.
- drop_cnt saturates at all-ones.
- pndng deasserting between grant and pop is a protocol violation; the bench flags it, and the RTL pops regardless.

Decomposition:
- Package bs_arbtr_pkg:
  - state enum {IDLE, POP, ROUTE, WAIT, PUSH}
  - function get_addr (field extract)
  - function mk_mask (addr, src -> DRVRS mask; illegal -> 0)
  - localparam for pointer width $clog2(DRVRS)
- Sub-module bs_wrr_grant: pointer plus credit logic, one instance per bus via generate. The top holds the per-bus FSM, data latch, timeout and drop counter.

Test Plan:
- Reset mid-WAIT: D_pop=16'h0255 from dev1 with full[2]=1; assert reset=0 on cycle 4 -> pop/push drop to 0 immediately; after release, busy=0, drop_cnt=0, no push of 16'h0255.
- Unicast: bus0 dev1 pending with D_pop=16'h0255, full=0 -> pop[1] at cycle 1, push=4'b0100 at cycle 3, D_push=16'h0255.
- Broadcast with backpressure: dev0 sends 16'hFF12 with full[3]=1 for 10 cycles -> no push until full[3]=0, then push=4'b1110 in a single cycle.
- Timeout: TMO=64; dev2 sends 16'h0177 with full[1] held at 1 -> no push; drop_cnt=1 exactly 64 cycles after entering WAIT; bus returns to IDLE.
- Illegal address: dev3 sends 16'h0599 -> no push; drop_cnt increments by 1 in ROUTE.
- WRR fairness: all four devices always pending, cfg_weight={1,1,2,3} for dev3..dev0 -> grant order 0,0,0,1,1,2,3 repeating; over 70 packets the counts are 30/20/10/10.

Source files
------------

// File: rtl/bs_arbtr_pkg.sv
// bs_arbtr_pkg: shared state encoding and destination decode helpers for the WRR bus arbiter.
package bs_arbtr_pkg;

    localparam int MAX_PKT = 64;
    localparam int MAX_DRVRS = 16;
    localparam int MAX_PTR_W = $clog2(MAX_DRVRS);

    typedef enum logic [2:0] {IDLE, POP, ROUTE, WAIT, PUSH} state_t;

    function automatic logic [31:0] get_addr(input logic [MAX_PKT-1:0] pkt, input int pckg_sz, input int addr_w);
        return 32'((pkt >> (pckg_sz - addr_w)) & ((64'(1) << addr_w) - 64'(1)));
    endfunction

    // An illegal destination yields an empty mask, which the caller counts as a drop.
    function automatic logic [MAX_DRVRS-1:0] mk_mask(input logic [31:0] addr, input logic [31:0] bcast,
                                                     input int src, input int drvrs);
        logic [MAX_DRVRS-1:0] all;
        all = (MAX_DRVRS'(1) << drvrs) - MAX_DRVRS'(1);
        return (addr == bcast) ? all & ~(MAX_DRVRS'(1) << src) :
               (addr < 32'(drvrs)) ? MAX_DRVRS'(1) << addr : '0;
    endfunction

endpackage

// File: rtl/bs_wrr_grant.sv
// bs_wrr_grant: weighted round-robin pointer and credit tracking for one bus.
module bs_wrr_grant
    import bs_arbtr_pkg::*;
#(
    parameter int DRVRS = 4,
    parameter int WEIGHT_W = 4,
    parameter int PTR_W = $clog2(DRVRS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DRVRS-1:0]          pndng,
    input  logic [DRVRS*WEIGHT_W-1:0] cfg_weight,
    input  logic                      en,
    output logic [PTR_W-1:0]          gnt
);

    logic [PTR_W-1:0] ptr, nxt, cand;
    logic [WEIGHT_W-1:0] credit, eff, w0, w_nxt, reload;
    logic init, hold;

    // Right after reset device 0 holds its full weight; init stands in for loading it asynchronously.
    assign w0 = cfg_weight[0 +: WEIGHT_W];
    assign eff = init ? ((w0 == '0) ? WEIGHT_W'(1) : w0) : credit;
    assign hold = pndng[ptr] && (eff != '0);
    assign w_nxt = cfg_weight[nxt*WEIGHT_W +: WEIGHT_W];
    assign reload = (w_nxt == '0) ? '0 : w_nxt - WEIGHT_W'(1);
    assign gnt = hold ? ptr : nxt;

    always_comb begin
        nxt = ptr;
        cand = '0;
        for (int i = DRVRS; i >= 1; i--) begin
            cand = PTR_W'((int'(ptr) + i) % DRVRS);
            if (pndng[cand]) nxt = cand;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
            credit <= '0;
            init <= 1'b1;
        end else if (en) begin
            init <= 1'b0;
            ptr <= hold ? ptr : nxt;
            credit <= hold ? eff - WEIGHT_W'(1) : reload;
        end
    end

endmodule

// File: rtl/bs_arbtr_wrr.sv
// bs_arbtr_wrr: per-bus WRR arbiter popping device FIFOs and routing packets by destination field.
module bs_arbtr_wrr
    import bs_arbtr_pkg::*;
#(
    parameter int BITS = 1,
    parameter int DRVRS = 4,
    parameter int PCKG_SZ = 16,
    parameter int ADDR_W = 8,
    parameter logic [ADDR_W-1:0] BROADCAST = {ADDR_W{1'b1}},
    parameter int WEIGHT_W = 4,
    parameter int TMO = 64,
    parameter int CNT_W = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [BITS*DRVRS-1:0]           pndng,
    input  logic [BITS*DRVRS*PCKG_SZ-1:0]   D_pop,
    output logic [BITS*DRVRS-1:0]           pop,
    input  logic [BITS*DRVRS-1:0]           full,
    output logic [BITS*DRVRS-1:0]           push,
    output logic [BITS*DRVRS*PCKG_SZ-1:0]   D_push,
    input  logic [DRVRS*WEIGHT_W-1:0]       cfg_weight,
    output logic [BITS-1:0]                 busy,
    output logic [BITS*CNT_W-1:0]           drop_cnt
);

    localparam int PTR_W = $clog2(DRVRS);
    localparam int TMO_W = $clog2(TMO + 1);

    for (genvar b = 0; b < BITS; b++) begin : g_bus
        logic [DRVRS-1:0] pnd, fl, pop_r, push_r, mask, rmask;
        logic [PTR_W-1:0] gnt, src;
        logic [PCKG_SZ-1:0] data, dpush;
        logic [TMO_W-1:0] tmo;
        logic [CNT_W-1:0] drop;
        state_t state;

        assign pnd = pndng[b*DRVRS +: DRVRS];
        assign fl = full[b*DRVRS +: DRVRS];
        assign rmask = DRVRS'(mk_mask(get_addr(MAX_PKT'(data), PCKG_SZ, ADDR_W), 32'(BROADCAST), int'(src), DRVRS));

        bs_wrr_grant #(.DRVRS(DRVRS), .WEIGHT_W(WEIGHT_W), .PTR_W(PTR_W)) u_grant (
            .clk(clk),
            .reset(reset),
            .pndng(pnd),
            .cfg_weight(cfg_weight),
            .en(state == IDLE && |pnd),
            .gnt(gnt)
        );

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state <= IDLE;
                src <= '0;
                data <= '0;
                dpush <= '0;
                mask <= '0;
                tmo <= '0;
                drop <= '0;
                pop_r <= '0;
                push_r <= '0;
            end else begin
                pop_r <= '0;
                push_r <= '0;
                case (state)
                    IDLE: if (|pnd) begin
                        pop_r <= DRVRS'(1) << gnt;
                        src <= gnt;
                        state <= POP;
                    end
                    POP: begin
                        data <= D_pop[(b*DRVRS + int'(src))*PCKG_SZ +: PCKG_SZ];
                        state <= ROUTE;
                    end
                    ROUTE: begin
                        mask <= rmask;
                        tmo <= '0;
                        if (rmask == '0) begin
                            drop <= drop + CNT_W'(!(&drop));
                            state <= IDLE;
                        end else if ((fl & rmask) == '0) begin
                            push_r <= rmask;
                            dpush <= data;
                            state <= PUSH;
                        end else begin
                            state <= WAIT;
                        end
                    end
                    WAIT: if ((fl & mask) == '0) begin
                        push_r <= mask;
                        dpush <= data;
                        state <= PUSH;
                    end else if (tmo == TMO_W'(TMO - 1)) begin
                        drop <= drop + CNT_W'(!(&drop));
                        state <= IDLE;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign pop[b*DRVRS +: DRVRS] = pop_r;
        assign push[b*DRVRS +: DRVRS] = push_r;
        assign D_push[b*DRVRS*PCKG_SZ +: DRVRS*PCKG_SZ] = {DRVRS{dpush}};
        assign busy[b] = state != IDLE;
        assign drop_cnt[b*CNT_W +: CNT_W] = drop;
    end

endmodule

// File: tb/tb_bs_arbtr_wrr.sv
// tb_bs_arbtr_wrr: directed checks of routing, backpressure, timeout, drops, reset and WRR order.
module tb_bs_arbtr_wrr;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0] pndng, pop, full, push;
    logic [63:0] d_pop, d_push;
    logic [15:0] cfg_weight;
    logic [0:0] busy;
    logic [15:0] drop_cnt;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bs_arbtr_wrr #(
        .BITS(1), .DRVRS(4), .PCKG_SZ(16), .ADDR_W(8), .BROADCAST(8'hFF),
        .WEIGHT_W(4), .TMO(64), .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pndng(pndng),
        .D_pop(d_pop),
        .pop(pop),
        .full(full),
        .push(push),
        .D_push(d_push),
        .cfg_weight(cfg_weight),
        .busy(busy),
        .drop_cnt(drop_cnt)
    );

    task automatic test_reset();
        reset = 1'b0;
        pndng = '0;
        full = '0;
        d_pop = '0;
        cfg_weight = {4'd1, 4'd1, 4'd2, 4'd3};
        repeat (2) @(negedge clk);
        tests++;
        if ({pop, push, busy} !== 9'b0) begin
            fails++;
            $display("FAIL reset_ctrl: pop=%b push=%b busy=%b, required all zero", pop, push, busy);
        end
        tests++;
        if (d_push !== 64'h0 || drop_cnt !== 16'h0) begin
            fails++;
            $display("FAIL reset_data: D_push=%h drop_cnt=%0d, required 0/0", d_push, drop_cnt);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_unicast();
        d_pop[16 +: 16] = 16'h0255;
        pndng = 4'b0010;
        @(negedge clk);
        tests++;
        if (pop !== 4'b0010 || busy !== 1'b1) begin
            fails++;
            $display("FAIL uni_pop: pop=%b busy=%b, required 0010/1", pop, busy);
        end
        pndng = '0;
        @(negedge clk);
        tests++;
        if (pop !== 4'b0 || push !== 4'b0) begin
            fails++;
            $display("FAIL uni_route: pop=%b push=%b, required 0000/0000", pop, push);
        end
        @(negedge clk);
        tests++;
        if (push !== 4'b0100 || d_push !== {4{16'h0255}}) begin
            fails++;
            $display("FAIL uni_push: push=%b D_push=%h, required 0100/%h", push, d_push, {4{16'h0255}});
        end
        @(negedge clk);
        tests++;
        if (push !== 4'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL uni_done: push=%b busy=%b, required 0000/0", push, busy);
        end
    endtask

    task automatic test_broadcast();
        logic seen;
        seen = 1'b0;
        d_pop[0 +: 16] = 16'hFF12;
        full = 4'b1000;
        pndng = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) pndng = '0;
            if (push !== 4'b0) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL bc_hold: push seen=%b while full[3]=1, required 0", seen);
        end
        full = '0;
        @(negedge clk);
        tests++;
        if (push !== 4'b1110 || d_push !== {4{16'hFF12}}) begin
            fails++;
            $display("FAIL bc_push: push=%b D_push=%h, required 1110/%h", push, d_push, {4{16'hFF12}});
        end
        @(negedge clk);
        tests++;
        if (push !== 4'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bc_done: push=%b busy=%b, required 0000/0", push, busy);
        end
    endtask

    task automatic test_timeout();
        logic seen;
        seen = 1'b0;
        d_pop[32 +: 16] = 16'h0177;
        full = 4'b0010;
        pndng = 4'b0100;
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            if (k == 1) pndng = '0;
            if (push !== 4'b0) seen = 1'b1;
        end
        tests++;
        if (drop_cnt !== 16'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL tmo_early: drop_cnt=%0d busy=%b, required 0/1", drop_cnt, busy);
        end
        @(negedge clk);
        tests++;
        if (drop_cnt !== 16'd1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL tmo_drop: drop_cnt=%0d busy=%b, required 1/0", drop_cnt, busy);
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL tmo_nopush: push seen=%b, required 0", seen);
        end
        full = '0;
    endtask

    task automatic test_illegal();
        logic seen;
        seen = 1'b0;
        d_pop[48 +: 16] = 16'h0599;
        pndng = 4'b1000;
        @(negedge clk);
        tests++;
        if (pop !== 4'b1000) begin
            fails++;
            $display("FAIL ill_pop: pop=%b, required 1000", pop);
        end
        pndng = '0;
        @(negedge clk);
        tests++;
        if (drop_cnt !== 16'd1) begin
            fails++;
            $display("FAIL ill_before: drop_cnt=%0d, required 1", drop_cnt);
        end
        @(negedge clk);
        if (push !== 4'b0) seen = 1'b1;
        tests++;
        if (drop_cnt !== 16'd2 || busy !== 1'b0 || seen !== 1'b0) begin
            fails++;
            $display("FAIL ill_drop: drop_cnt=%0d busy=%b push_seen=%b, required 2/0/0", drop_cnt, busy, seen);
        end
    endtask

    task automatic test_reset_wait();
        logic seen;
        seen = 1'b0;
        d_pop[16 +: 16] = 16'h0255;
        full = 4'b0100;
        pndng = 4'b0010;
        @(negedge clk);
        pndng = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (pop !== 4'b0 || push !== 4'b0 || busy !== 1'b0 || drop_cnt !== 16'd0 || d_push !== 64'h0) begin
            fails++;
            $display("FAIL rst_wait: pop=%b push=%b busy=%b drop=%0d D_push=%h, required all zero",
                     pop, push, busy, drop_cnt, d_push);
        end
        @(negedge clk);
        reset = 1'b1;
        full = '0;
        repeat (8) begin
            @(negedge clk);
            if (push !== 4'b0) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0 || busy !== 1'b0 || drop_cnt !== 16'd0) begin
            fails++;
            $display("FAIL rst_after: push_seen=%b busy=%b drop=%0d, required 0/0/0", seen, busy, drop_cnt);
        end
    endtask

    task automatic test_wrr();
        int pat[7] = '{0, 0, 0, 1, 1, 2, 3};
        int cnt[4] = '{0, 0, 0, 0};
        int npk = 0;
        int bad = 0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        d_pop = {16'h0099, 16'h0288, 16'h0377, 16'h0166};
        full = '0;
        pndng = 4'b1111;
        for (int c = 0; c < 400 && npk < 70; c++) begin
            @(negedge clk);
            if (pop !== 4'b0) begin
                if (!$onehot(pop) || pop !== (4'b1 << pat[npk % 7])) bad++;
                for (int d = 0; d < 4; d++) if (pop[d]) cnt[d]++;
                npk++;
            end
        end
        pndng = '0;
        tests++;
        if (npk != 70) begin
            fails++;
            $display("FAIL wrr_budget: %0d packets granted, required 70", npk);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL wrr_order: %0d grants out of order, required 0", bad);
        end
        tests++;
        if (cnt[0] != 30 || cnt[1] != 20 || cnt[2] != 10 || cnt[3] != 10) begin
            fails++;
            $display("FAIL wrr_counts: %0d/%0d/%0d/%0d, required 30/20/10/10", cnt[0], cnt[1], cnt[2], cnt[3]);
        end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_broadcast();
        test_timeout();
        test_illegal();
        test_reset_wait();
        test_wrr();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
